// File: rtl/mod_counter_if.sv
// mod_counter_if -- control/status bundle for mod_counter.
//
// Purpose:
//   Groups the counter's control inputs and its registered status outputs
//   into one interface. clk and rst are not carried here; they stay as plain
//   ports on the counter.
//
// Parameter:
//   WIDTH     counter width in bits. It must match the WIDTH of the
//             mod_counter instance that the interface is attached to.
//
// Signals:
//   en        count enable; a step is requested on each cycle it is high
//   up        direction, 1 = increment, 0 = decrement
//   sat       limit mode, 0 = wrap, 1 = saturate
//   load      parallel load strobe
//   load_val  value to load; values above MAX are clamped to MAX
//   count     current count, registered
//   tc        terminal-count pulse, registered
//   at_max    count == MAX, decoded from the count register
//   at_zero   count == 0, decoded from the count register
//
// Modports:
//   master    the controller side; drives the controls and reads the status
//   slave     the counter side; reads the controls and drives the status
interface mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_max;
    logic             at_zero;

    modport master (
        output en,
        output up,
        output sat,
        output load,
        output load_val,
        input  count,
        input  tc,
        input  at_max,
        input  at_zero
    );

    modport slave (
        input  en,
        input  up,
        input  sat,
        input  load,
        input  load_val,
        output count,
        output tc,
        output at_max,
        output at_zero
    );
endinterface

// File: rtl/mod_counter.sv
// mod_counter -- parametrised modulo up/down counter.
//
// Purpose:
//   Counts over the range 0..MAX. Each step goes up or down according to the
//   direction input. At a limit the count either wraps or saturates, according
//   to the sat input. A parallel load clamps its value to MAX. The counter
//   produces a registered terminal-count pulse (tc), and two limit flags that
//   are decoded from the count register.
//
// Parameters:
//   WIDTH     counter width, 1..16
//   MAX       terminal value, 1..2**WIDTH-1 (default 2**WIDTH-1)
//   PRESCALE  enable divider, 1..255. It is used only when the macro
//             MOD_COUNTER_PRESCALE_EN is defined.
//
// Optional feature (compile-time macro MOD_COUNTER_PRESCALE_EN):
//   Defined   an 8-bit prescaler counts cycles with en high. A step happens
//             only on every PRESCALE-th such cycle. A cycle with en low leaves
//             the prescaler unchanged. rst and load clear the prescaler.
//   Undefined every cycle with en high is a step, and no prescaler register
//             exists.
//
// Ports:
//   clk       single clock; all state changes on its rising edge
//   rst       synchronous reset, active-high
//   bus       mod_counter_if.slave. Inputs: en, up, sat, load, load_val.
//             Outputs: count, tc, at_max, at_zero.
//
// Priority on each edge: rst > load > step > hold.
module mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst,
    mod_counter_if.slave   bus
);

    // All limit comparisons are made against WIDTH-bit constants.
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MAX_M1_V = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V   = '0;

    // Reject illegal parameter values at elaboration time.
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("mod_counter: WIDTH must be in 1..16");
    end
    if (MAX < 1 || MAX > (2 ** WIDTH) - 1) begin : g_bad_max
        $error("mod_counter: MAX must be in 1..2**WIDTH-1");
    end
    if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
        $error("mod_counter: PRESCALE must be in 1..255");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             tc_q;
    logic             tc_d;
    logic             step;
    logic             cnt_at_max;
    logic             cnt_at_zero;

    assign cnt_at_max   = (count_q == MAX_V);
    assign cnt_at_zero  = (count_q == ZERO_V);
    assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;

`ifdef MOD_COUNTER_PRESCALE_EN
    localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

    logic [7:0] pre_q;

    // A step fires on the en-high cycle that completes a period. On that
    // same edge the prescaler returns to 0.
    assign step = bus.en && (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst || bus.load) begin
            pre_q <= 8'd0;
        end else if (bus.en) begin
            pre_q <= (pre_q == PRE_LAST) ? 8'd0 : (pre_q + 8'd1);
        end
    end
`else
    assign step = bus.en;
`endif

    // Next-state logic for the count and tc. tc defaults to 0; only a wrap,
    // or arrival at a limit in saturate mode, raises it.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (bus.up) begin
                if (!cnt_at_max) begin
                    count_d = count_q + ONE_V;
                    // In saturate mode, arriving at MAX is itself the event.
                    tc_d    = bus.sat && (count_q == MAX_M1_V);
                end else if (!bus.sat) begin
                    count_d = ZERO_V;
                    tc_d    = 1'b1;
                end
            end else begin
                if (!cnt_at_zero) begin
                    count_d = count_q - ONE_V;
                    tc_d    = bus.sat && (count_q == ONE_V);
                end else if (!bus.sat) begin
                    count_d = MAX_V;
                    tc_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ZERO_V;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.at_max  = cnt_at_max;
    assign bus.at_zero = cnt_at_zero;

    // No state above MAX can be reached.
    a_count_in_range : assert property (
        @(posedge clk) disable iff (rst) (count_q <= MAX_V)
    );

    // Because MAX is at least 1, the two limit flags can never be high together.
    a_flags_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(cnt_at_max && cnt_at_zero)
    );

endmodule

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

    localparam int WIDTH    = 4;
    localparam int MAX      = 9;
    localparam int PRESCALE = 4;
`ifdef MOD_COUNTER_PRESCALE_EN
    localparam int P_EFF = PRESCALE;
`else
    localparam int P_EFF = 1;
`endif

    logic clk;
    logic rst;

    mod_counter_if #(.WIDTH(WIDTH)) bus ();

    mod_counter #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. It works on plain integers from the counting rules and
    // counts en-high cycles against the period.
    int m_count = 0;
    int m_tc    = 0;
    int m_pre   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_count = 0;
            m_tc    = 0;
            m_pre   = 0;
        end else if (bus.load) begin
            m_count = (int'(bus.load_val) > MAX) ? MAX : int'(bus.load_val);
            m_tc    = 0;
            m_pre   = 0;
        end else begin
            bit stepping;
            stepping = 1'b0;
            m_tc     = 0;
            if (bus.en) begin
                m_pre = m_pre + 1;
                if (m_pre == P_EFF) begin
                    stepping = 1'b1;
                    m_pre    = 0;
                end
            end
            if (stepping) begin
                if (bus.up) begin
                    if (m_count < MAX) begin
                        m_count = m_count + 1;
                        if (bus.sat && m_count == MAX) m_tc = 1;
                    end else if (!bus.sat) begin
                        m_count = 0;
                        m_tc    = 1;
                    end
                end else begin
                    if (m_count > 0) begin
                        m_count = m_count - 1;
                        if (bus.sat && m_count == 0) m_tc = 1;
                    end else if (!bus.sat) begin
                        m_count = MAX;
                        m_tc    = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_count",   {28'd0, bus.count}, m_count);
            chk("model_tc",      {31'd0, bus.tc},    m_tc);
            chk("model_at_max",  {31'd0, bus.at_max},  (m_count == MAX) ? 1 : 0);
            chk("model_at_zero", {31'd0, bus.at_zero}, (m_count == 0) ? 1 : 0);
        end
    end

    // Drives one cycle of inputs and returns 2 time units after the edge.
    task automatic cyc(input logic r, input logic e, input logic u, input logic s,
                       input logic l, input int lv);
        rst          = r;
        bus.en       = e;
        bus.up       = u;
        bus.sat      = s;
        bus.load     = l;
        bus.load_val = 4'(lv);
        @(posedge clk);
        #2;
    endtask

    // One full step: enough en-high cycles to produce exactly one step.
    task automatic step_expect(input string nm, input logic u, input logic s,
                               input int ec, input int etc);
        for (int i = 0; i < P_EFF - 1; i++) cyc(1'b0, 1'b1, u, s, 1'b0, 0);
        cyc(1'b0, 1'b1, u, s, 1'b0, 0);
        chk(nm, {28'd0, bus.count}, ec);
        chk({nm, "_tc"}, {31'd0, bus.tc}, etc);
    endtask

    task automatic load_expect(input string nm, input int lv, input int ec);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, lv);
        chk(nm, {28'd0, bus.count}, ec);
        chk({nm, "_tc"}, {31'd0, bus.tc}, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.up       = 1'b1;
        bus.sat      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // Reset held for three cycles while en and up are high.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
            chk_en = 1'b1;
            chk($sformatf("rst_count%0d", i), {28'd0, bus.count}, 0);
            chk($sformatf("rst_tc%0d", i), {31'd0, bus.tc}, 0);
            chk($sformatf("rst_zero%0d", i), {31'd0, bus.at_zero}, 1);
        end
        step_expect("rst_release", 1'b1, 1'b0, 1, 0);

        // Wrap upward over 0..9.
        load_expect("ld0", 0, 0);
        for (int i = 1; i <= 10; i++)
            step_expect($sformatf("wrapup%0d", i), 1'b1, 1'b0, i % 10, (i == 10) ? 1 : 0);

        // Wrap downward after a load, then a load that must clamp.
        load_expect("ld3", 3, 3);
        step_expect("dn2", 1'b0, 1'b0, 2, 0);
        step_expect("dn1", 1'b0, 1'b0, 1, 0);
        step_expect("dn0", 1'b0, 1'b0, 0, 0);
        step_expect("dn9", 1'b0, 1'b0, 9, 1);
        load_expect("ld12", 12, 9);

        // Saturate mode.
        load_expect("ld7", 7, 7);
        step_expect("sat8", 1'b1, 1'b1, 8, 0);
        step_expect("sat9", 1'b1, 1'b1, 9, 1);
        chk("sat9_atmax", {31'd0, bus.at_max}, 1);
        step_expect("sat9h1", 1'b1, 1'b1, 9, 0);
        step_expect("sat9h2", 1'b1, 1'b1, 9, 0);
        for (int i = 1; i <= 10; i++)
            step_expect($sformatf("satdn%0d", i), 1'b0, 1'b1,
                        (9 - i < 0) ? 0 : 9 - i, (i == 9) ? 1 : 0);
        chk("satdn_atzero", {31'd0, bus.at_zero}, 1);

        // Events in the same cycle: load wins over a step, and rst wins over load.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5);
        chk("load_vs_step", {28'd0, bus.count}, 5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        chk("rst_vs_load", {28'd0, bus.count}, 0);

`ifdef MOD_COUNTER_PRESCALE_EN
        // Dropping en partway through a period delays the step.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("pre_gap_hold", {28'd0, bus.count}, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("pre_gap_step", {28'd0, bus.count}, 1);
        // A load partway through a period starts the period again.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        load_expect("pre_ld", 0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("pre_ld_hold", {28'd0, bus.count}, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("pre_ld_step", {28'd0, bus.count}, 1);
`endif

        // Random phase. Direction and mode change only occasionally, so long
        // runs reach both limits.
        begin
            logic r_up;
            logic r_sat;
            r_up  = 1'b1;
            r_sat = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) r_up  = ~r_up;
                if ($urandom_range(0, 31) == 0) r_sat = ~r_sat;
                cyc(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    r_up, r_sat,
                    ($urandom_range(0, 19) == 0),
                    int'($urandom_range(0, 15)));
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
